pc_gen: RTL and testbench

- Stateful program-counter unit that replaces the purely combinational next-PC path.
- Owns the architectural PC register and computes sequential, branch, JAL and JALR targets.
- Supports stalls and optional 16-bit instruction alignment (C extension).
- A misaligned control-transfer target raises a recorded, precise trap and redirects to a trap vector; it does not abort simulation.
- Sits between decode/execute (control flags, immediates, rs1) and instruction fetch (consumes pc).

---
 rtl/pc_gen.sv | 116 +++++++++++
 tb/tb_pc_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter unit: owns the PC, selects sequential/branch/JAL/JALR targets
// and raises a precise trap on a misaligned control-transfer target.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 32,
    parameter int              CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 valid_in,
    input  logic                 is_branch,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic                 branch_taken,
    input  logic                 is_compressed,
    input  logic [XLEN-1:0]      imm_data,
    input  logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc_next,
    output logic                 trap_valid,
    output logic [XLEN-1:0]      trap_pc,
    output logic [XLEN-1:0]      trap_addr,
    output logic [CNT_WIDTH-1:0] instret
);

    if (IALIGN != 16 && IALIGN != 32) begin : g_bad_ialign
        $fatal(1, "pc_gen: IALIGN must be 16 or 32");
    end

    if (RESET_VECTOR[0] || (IALIGN == 32 && RESET_VECTOR[1])) begin : g_bad_rv
        $fatal(1, "pc_gen: RESET_VECTOR not aligned to IALIGN");
    end

    if (TRAP_VECTOR[0] || (IALIGN == 32 && TRAP_VECTOR[1])) begin : g_bad_tv
        $fatal(1, "pc_gen: TRAP_VECTOR not aligned to IALIGN");
    end

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] seq_tgt;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] tgt;
    logic            xfer;
    logic            misaligned;
    logic            adv;
    logic            trap;

    assign step     = (IALIGN == 16 && is_compressed) ? XLEN'(2) : XLEN'(4);
    assign seq_tgt  = pc + step;
    assign br_tgt   = pc + imm_data;
    assign jalr_sum = rs1_data + imm_data;
    assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

    // Flags may overlap, so this is a true priority chain.
    always_comb begin
        tgt  = seq_tgt;
        xfer = 1'b0;
        priority case (1'b1)
            is_jalr: begin
                tgt  = jalr_tgt;
                xfer = 1'b1;
            end
            is_jal: begin
                tgt  = br_tgt;
                xfer = 1'b1;
            end
            (is_branch && branch_taken): begin
                tgt  = br_tgt;
                xfer = 1'b1;
            end
            default: begin
                tgt  = seq_tgt;
                xfer = 1'b0;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if (xfer) begin
            if (IALIGN == 16) misaligned = tgt[0];
            else              misaligned = |tgt[1:0];
        end
    end

    assign pc_next = misaligned ? TRAP_VECTOR : tgt;
    assign adv     = valid_in & ~stall;
    assign trap    = adv & misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            trap_valid <= 1'b0;
            trap_pc    <= '0;
            trap_addr  <= '0;
            instret    <= '0;
        end else begin
            trap_valid <= trap;
            if (adv) begin
                pc <= pc_next;
                // A faulting instruction does not retire.
                if (trap) begin
                    trap_pc   <= pc;
                    trap_addr <= tgt;
                end else begin
                    instret <= instret + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance per alignment mode,
// driven with shared stimulus and checked against hand-computed values.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        valid_in;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        branch_taken;
    logic        is_compressed;
    logic [31:0] imm_data;
    logic [31:0] rs1_data;

    logic [31:0] pc_a, pc_next_a, trap_pc_a, trap_addr_a, instret_a;
    logic        trap_valid_a;
    logic [31:0] pc_c, pc_next_c, trap_pc_c, trap_addr_c, instret_c;
    logic        trap_valid_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_gen #(.IALIGN(32)) u32 (
        .clk(clk), .rst(rst), .stall(stall), .valid_in(valid_in),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .branch_taken(branch_taken), .is_compressed(is_compressed),
        .imm_data(imm_data), .rs1_data(rs1_data),
        .pc(pc_a), .pc_next(pc_next_a), .trap_valid(trap_valid_a),
        .trap_pc(trap_pc_a), .trap_addr(trap_addr_a), .instret(instret_a)
    );

    pc_gen #(.IALIGN(16)) u16 (
        .clk(clk), .rst(rst), .stall(stall), .valid_in(valid_in),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .branch_taken(branch_taken), .is_compressed(is_compressed),
        .imm_data(imm_data), .rs1_data(rs1_data),
        .pc(pc_c), .pc_next(pc_next_c), .trap_valid(trap_valid_c),
        .trap_pc(trap_pc_c), .trap_addr(trap_addr_c), .instret(instret_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        stall         = 1'b0;
        valid_in      = 1'b0;
        is_branch     = 1'b0;
        is_jal        = 1'b0;
        is_jalr       = 1'b0;
        branch_taken  = 1'b0;
        is_compressed = 1'b0;
        imm_data      = '0;
        rs1_data      = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [31:0] a);
        clr();
        valid_in = 1'b1;
        is_jalr  = 1'b1;
        rs1_data = a;
        step();
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step();
        chk("rst_pc", pc_a, 0);
        chk("rst_tv", trap_valid_a, 0);
        chk("rst_tpc", trap_pc_a, 0);
        chk("rst_taddr", trap_addr_a, 0);
        chk("rst_instret", instret_a, 0);
        chk("rst_pc_next", pc_next_a, 32'h4);
        rst = 1'b0;

        valid_in = 1'b1;
        step();
        chk("seq1_pc", pc_a, 32'h4);
        step();
        chk("seq2_pc", pc_a, 32'h8);
        step();
        chk("seq3_pc", pc_a, 32'hC);
        chk("seq3_tv", trap_valid_a, 0);
        chk("seq3_instret", instret_a, 3);
        chk("seq3_pc16", pc_c, 32'hC);

        jump_to(32'h10);
        chk("jmp10_pc", pc_a, 32'h10);
        clr();
        valid_in     = 1'b1;
        is_branch    = 1'b1;
        branch_taken = 1'b1;
        imm_data     = 32'hFFFF_FFF0;
        #1;
        chk("br_taken_pc_next", pc_next_a, 32'h0);
        step();
        chk("br_taken_pc", pc_a, 32'h0);
        jump_to(32'h10);
        clr();
        valid_in  = 1'b1;
        is_branch = 1'b1;
        imm_data  = 32'hFFFF_FFF0;
        step();
        chk("br_nt_pc", pc_a, 32'h14);
        chk("br_nt_instret", instret_a, 7);

        jump_to(32'h20);
        clr();
        valid_in = 1'b1;
        is_jal   = 1'b1;
        imm_data = 32'h6;
        #1;
        chk("jal_mis_pc_next", pc_next_a, 32'h100);
        chk("jal_mis_pc_next16", pc_next_c, 32'h26);
        step();
        chk("jal_mis_pc", pc_a, 32'h100);
        chk("jal_mis_tv", trap_valid_a, 1);
        chk("jal_mis_tpc", trap_pc_a, 32'h20);
        chk("jal_mis_taddr", trap_addr_a, 32'h26);
        chk("jal_mis_instret", instret_a, 8);
        chk("jal16_pc", pc_c, 32'h26);
        chk("jal16_tv", trap_valid_c, 0);
        chk("jal16_instret", instret_c, 9);
        clr();
        step();
        chk("pulse_end_tv", trap_valid_a, 0);
        chk("idle_pc", pc_a, 32'h100);
        chk("sticky_tpc", trap_pc_a, 32'h20);

        clr();
        valid_in = 1'b1;
        is_jalr  = 1'b1;
        rs1_data = 32'h1001;
        imm_data = 32'h4;
        step();
        chk("jalr_pc", pc_a, 32'h1004);
        chk("jalr_pc16", pc_c, 32'h1004);
        is_jal = 1'b1;
        step();
        chk("jalr_prio_pc", pc_a, 32'h1004);
        chk("jalr_prio_instret", instret_a, 10);
        clr();
        valid_in      = 1'b1;
        is_compressed = 1'b1;
        step();
        chk("rvc_pc16", pc_c, 32'h1006);
        chk("rvc_pc32", pc_a, 32'h1008);

        clr();
        valid_in = 1'b1;
        is_jalr  = 1'b1;
        rs1_data = 32'h1002;
        step();
        chk("jalr_mis_pc", pc_a, 32'h100);
        chk("jalr_mis_tv", trap_valid_a, 1);
        chk("jalr_mis_tpc", trap_pc_a, 32'h1008);
        chk("jalr_mis_taddr", trap_addr_a, 32'h1002);
        chk("jalr16_pc", pc_c, 32'h1002);
        chk("jalr16_tv", trap_valid_c, 0);
        clr();
        step();

        jump_to(32'h200);
        clr();
        valid_in = 1'b1;
        stall    = 1'b1;
        is_jal   = 1'b1;
        imm_data = 32'h2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_pc", pc_a, 32'h200);
            chk("stall_tv", trap_valid_a, 0);
            chk("stall_instret", instret_a, 12);
            chk("stall_taddr", trap_addr_a, 32'h1002);
        end
        stall = 1'b0;
        step();
        chk("rel_pc", pc_a, 32'h100);
        chk("rel_tv", trap_valid_a, 1);
        chk("rel_tpc", trap_pc_a, 32'h200);
        chk("rel_taddr", trap_addr_a, 32'h202);
        chk("rel_instret", instret_a, 12);
        chk("rel_pc16", pc_c, 32'h202);
        valid_in = 1'b0;
        step();
        chk("rel_once_tv", trap_valid_a, 0);

        valid_in = 1'b1;
        step();
        chk("b2b1_tv", trap_valid_a, 1);
        chk("b2b1_tpc", trap_pc_a, 32'h100);
        chk("b2b1_taddr", trap_addr_a, 32'h102);
        imm_data = 32'h6;
        step();
        chk("b2b2_tv", trap_valid_a, 1);
        chk("b2b2_taddr", trap_addr_a, 32'h106);
        chk("b2b2_instret", instret_a, 12);

        jump_to(32'hFFFF_FFFC);
        chk("wrap_pre_pc", pc_a, 32'hFFFF_FFFC);
        clr();
        valid_in = 1'b1;
        step();
        chk("wrap_pc", pc_a, 32'h0);
        step();
        chk("wrap_next_pc", pc_a, 32'h4);
        chk("wrap_instret", instret_a, 15);

        stall = 1'b1;
        rst   = 1'b1;
        step();
        chk("mid_rst_pc", pc_a, 32'h0);
        chk("mid_rst_instret", instret_a, 0);
        chk("mid_rst_tpc", trap_pc_a, 0);
        chk("mid_rst_pc16", pc_c, 32'h0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
